// File: rtl/parallel_sort_pkg.sv
// -----------------------------------------------------------------------------
// parallel_sort_pkg
// Shared definitions for the parallel rank sorter:
//   - one-hot FSM state encoding (IDLE, CMP, RANK, SCAT)
//   - beats(): pairwise "i is placed after j" predicate with index tie-break
//   - rank_width(): width of an index/rank for a given element count
// -----------------------------------------------------------------------------
package parallel_sort_pkg;

    // One-hot sorter states.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CMP  = 4'b0010,
        RANK = 4'b0100,
        SCAT = 4'b1000
    } sort_state_t;

    // Width of an element index / rank; never below one bit.
    function automatic int rank_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Element i beats element j when it must land at a higher output position.
    // Samples are zero-extended to 32 bits by the caller, so DW is limited to 32.
    // Equal values are ordered by input index in both directions, which keeps
    // the sort stable and guarantees the ranks form a permutation.
    function automatic logic beats(input logic [31:0] di,
                                   input logic [31:0] dj,
                                   input int          i,
                                   input int          j,
                                   input logic        desc);
        logic tie_win;
        tie_win = (di == dj) && (i > j);
        if (desc) begin
            return (di < dj) || tie_win;
        end else begin
            return (di > dj) || tie_win;
        end
    endfunction

endpackage

// File: rtl/rank_popcount.sv
// -----------------------------------------------------------------------------
// rank_popcount
// Combinational population count of one beat-matrix row.
// Ports:
//   row_bits  in  DN  one row of the beat matrix (diagonal bit always 0)
//   count     out IW  number of set bits = rank of the row's element
// Because the diagonal is zero at most DN-1 bits are set, so IW bits suffice.
// -----------------------------------------------------------------------------
module rank_popcount #(
    parameter int DN = 25,
    parameter int IW = 5
) (
    input  logic [DN-1:0] row_bits,
    output logic [IW-1:0] count
);

    logic [IW-1:0] sum_s;

    // Sum the row bits; synthesis balances the chain into an adder tree.
    always_comb begin
        sum_s = {IW{1'b0}};
        for (int k = 0; k < DN; k++) begin
            sum_s = sum_s + IW'(row_bits[k]);
        end
    end

    assign count = sum_s;

endmodule

// File: rtl/parallel_rank_sort.sv
// -----------------------------------------------------------------------------
// parallel_rank_sort
// Parallel rank sorter: DN unsigned DW-bit samples are compared all-pairs,
// each element's rank is the popcount of its beat-matrix row, and the
// elements plus their original indices are scattered to their rank position.
// Ascending or descending order is chosen per sort; ties keep input order.
// Ports:
//   clk              in   1      clock
//   rst              in   1      asynchronous active-high reset
//   sort_sig         in   1      start request, sampled only in IDLE
//   descend          in   1      0 = ascending, 1 = descending (with sort_sig)
//   data_unsort      in   DW*DN  element k at [k*DW +: DW]
//   data_sorted      out  DW*DN  sorted element p at [p*DW +: DW]
//   sequence_sorted  out  IW*DN  original index of position p at [p*IW +: IW]
//   busy             out  1      high while a sort is in progress
//   sort_finish      out  1      one-cycle pulse, outputs valid from here on
// Latency: sort_finish rises 3 edges after the edge that samples sort_sig.
// -----------------------------------------------------------------------------
module parallel_rank_sort
    import parallel_sort_pkg::*;
#(
    parameter  int DN = 25,
    parameter  int DW = 8,
    localparam int IW = rank_width(DN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sort_sig,
    input  logic             descend,
    input  logic [DW*DN-1:0] data_unsort,
    output logic [DW*DN-1:0] data_sorted,
    output logic [IW*DN-1:0] sequence_sorted,
    output logic             busy,
    output logic             sort_finish
);

    sort_state_t      state_r;
    sort_state_t      next_s;
    logic             busy_r;
    logic             finish_r;
    logic             desc_r;
    logic [DW*DN-1:0] data_r;
    logic [DN-1:0]    beat_r [DN];
    logic [IW-1:0]    rank_s [DN];
    logic [IW-1:0]    rank_r [DN];
    logic [DW*DN-1:0] data_sorted_r;
    logic [IW*DN-1:0] seq_sorted_r;

    // Next-state logic: one pass through CMP, RANK, SCAT per accepted start.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (sort_sig) begin
                    next_s = CMP;
                end else begin
                    next_s = IDLE;
                end
            end
            CMP:     next_s = RANK;
            RANK:    next_s = SCAT;
            SCAT:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register with busy and finish registered alongside it, so busy
    // is already low in the sort_finish cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
        end else begin
            state_r  <= next_s;
            busy_r   <= (next_s != IDLE);
            finish_r <= (state_r == SCAT);
        end
    end

    // One popcount per matrix row produces that element's rank.
    for (genvar g = 0; g < DN; g++) begin : g_rank
        rank_popcount #(
            .DN (DN),
            .IW (IW)
        ) u_rank_popcount (
            .row_bits (beat_r[g]),
            .count    (rank_s[g])
        );
    end

    // Datapath: latch inputs, build the beat matrix, register ranks, scatter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_r        <= 1'b0;
            data_r        <= {(DW*DN){1'b0}};
            data_sorted_r <= {(DW*DN){1'b0}};
            seq_sorted_r  <= {(IW*DN){1'b0}};
            for (int i = 0; i < DN; i++) begin
                beat_r[i] <= {DN{1'b0}};
                rank_r[i] <= {IW{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (sort_sig) begin
                        data_r <= data_unsort;
                        desc_r <= descend;
                    end
                end
                CMP: begin
                    for (int i = 0; i < DN; i++) begin
                        for (int j = 0; j < DN; j++) begin
                            if (i == j) begin
                                beat_r[i][j] <= 1'b0;
                            end else begin
                                beat_r[i][j] <= beats(32'(data_r[i*DW +: DW]),
                                                      32'(data_r[j*DW +: DW]),
                                                      i, j, desc_r);
                            end
                        end
                    end
                end
                RANK: begin
                    for (int i = 0; i < DN; i++) begin
                        rank_r[i] <= rank_s[i];
                    end
                end
                SCAT: begin
                    // Ranks are a permutation, so every position is written once.
                    for (int i = 0; i < DN; i++) begin
                        data_sorted_r[rank_r[i]*DW +: DW] <= data_r[i*DW +: DW];
                        seq_sorted_r[rank_r[i]*IW +: IW]  <= IW'(i);
                    end
                end
                default: begin
                    desc_r <= desc_r;
                end
            endcase
        end
    end

    assign data_sorted     = data_sorted_r;
    assign sequence_sorted = seq_sorted_r;
    assign busy            = busy_r;
    assign sort_finish     = finish_r;

endmodule

// File: tb/tb_parallel_rank_sort.sv
// -----------------------------------------------------------------------------
// tb_parallel_rank_sort
// Directed, table-driven bench for parallel_rank_sort with DN=5, DW=8.
// -----------------------------------------------------------------------------
module tb_parallel_rank_sort;

    localparam int DN = 5;
    localparam int DW = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [DW*DN-1:0] d;
        logic             desc;
        logic [DW*DN-1:0] exp_d;
        logic [IW*DN-1:0] exp_i;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             sort_sig;
    logic             descend;
    logic [DW*DN-1:0] data_unsort;
    logic [DW*DN-1:0] data_sorted;
    logic [IW*DN-1:0] sequence_sorted;
    logic             busy;
    logic             sort_finish;

    int   checks;
    int   errors;
    vec_t vecs [8];

    parallel_rank_sort #(
        .DN (DN),
        .DW (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sort_sig        (sort_sig),
        .descend         (descend),
        .data_unsort     (data_unsort),
        .data_sorted     (data_sorted),
        .sequence_sorted (sequence_sorted),
        .busy            (busy),
        .sort_finish     (sort_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element 0 in the low byte.
    function automatic logic [DW*DN-1:0] pd(input int a0, input int a1, input int a2,
                                            input int a3, input int a4);
        return {8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [IW*DN-1:0] pi(input int a0, input int a1, input int a2,
                                            input int a3, input int a4);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full sort of one table entry: latency, busy window, pulse width, results.
    task automatic run_vec(input int n);
        int   lat;
        bit   seen;
        bit   busy_ok;
        vec_t v;
        v = vecs[n];
        @(negedge clk);
        data_unsort = v.d;
        descend     = v.desc;
        sort_sig    = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_busy_start", n), 64'(busy), 64'd1);
        @(negedge clk);
        sort_sig    = 1'b0;
        data_unsort = ~v.d;
        descend     = ~v.desc;
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (sort_finish) begin
                seen = 1'b1;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        chk($sformatf("vec%0d_latency", n), 64'(lat), 64'd3);
        chk($sformatf("vec%0d_busy_window", n), 64'(busy_ok), 64'd1);
        chk($sformatf("vec%0d_busy_at_finish", n), 64'(busy), 64'd0);
        chk($sformatf("vec%0d_data", n), 64'(data_sorted), 64'(v.exp_d));
        chk($sformatf("vec%0d_index", n), 64'(sequence_sorted), 64'(v.exp_i));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_finish_one_cycle", n), 64'(sort_finish), 64'd0);
        chk($sformatf("vec%0d_data_hold", n), 64'(data_sorted), 64'(v.exp_d));
    endtask

    initial begin
        int sel [3];
        int finishes;
        int late_finish;

        checks = 0;
        errors = 0;

        vecs[0] = '{d: pd(30, 10, 50, 20, 40), desc: 1'b0,
                    exp_d: pd(10, 20, 30, 40, 50), exp_i: pi(1, 3, 0, 4, 2)};
        vecs[1] = '{d: pd(30, 10, 50, 20, 40), desc: 1'b1,
                    exp_d: pd(50, 40, 30, 20, 10), exp_i: pi(2, 4, 0, 3, 1)};
        vecs[2] = '{d: pd(7, 7, 3, 7, 3), desc: 1'b0,
                    exp_d: pd(3, 3, 7, 7, 7), exp_i: pi(2, 4, 0, 1, 3)};
        vecs[3] = '{d: pd(7, 7, 3, 7, 3), desc: 1'b1,
                    exp_d: pd(7, 7, 7, 3, 3), exp_i: pi(0, 1, 3, 2, 4)};
        vecs[4] = '{d: pd(255, 255, 255, 255, 255), desc: 1'b0,
                    exp_d: pd(255, 255, 255, 255, 255), exp_i: pi(0, 1, 2, 3, 4)};
        vecs[5] = '{d: pd(255, 255, 255, 255, 255), desc: 1'b1,
                    exp_d: pd(255, 255, 255, 255, 255), exp_i: pi(0, 1, 2, 3, 4)};
        vecs[6] = '{d: pd(0, 255, 1, 254, 128), desc: 1'b0,
                    exp_d: pd(0, 1, 128, 254, 255), exp_i: pi(0, 2, 4, 3, 1)};
        vecs[7] = '{d: pd(0, 0, 0, 0, 0), desc: 1'b0,
                    exp_d: pd(0, 0, 0, 0, 0), exp_i: pi(0, 1, 2, 3, 4)};

        rst         = 1'b1;
        sort_sig    = 1'b0;
        descend     = 1'b0;
        data_unsort = '0;

        // Reset state.
        @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_finish", 64'(sort_finish), 64'd0);
        chk("reset_data", 64'(data_sorted), 64'd0);
        chk("reset_index", 64'(sequence_sorted), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 8; n++) begin
            run_vec(n);
        end

        // sort_sig held high 12 cycles; only edges 0, 4, 8 sample a new sort.
        sel[0] = 0;
        sel[1] = 2;
        sel[2] = 6;
        finishes = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            sort_sig = 1'b1;
            if (c % 4 == 0) begin
                data_unsort = vecs[sel[c / 4]].d;
                descend     = 1'b0;
            end else begin
                data_unsort = {5{8'(c * 37 + 5)}} ^ pd(1, 2, 3, 4, 5);
                descend     = c[0];
            end
            @(posedge clk);
            #1;
            chk($sformatf("held_c%0d_busy", c), 64'(busy), 64'((c % 4) != 3));
            chk($sformatf("held_c%0d_finish", c), 64'(sort_finish), 64'((c % 4) == 3));
            if (sort_finish) begin
                finishes++;
                chk($sformatf("held_c%0d_data", c), 64'(data_sorted),
                    64'(vecs[sel[c / 4]].exp_d));
                chk($sformatf("held_c%0d_index", c), 64'(sequence_sorted),
                    64'(vecs[sel[c / 4]].exp_i));
            end
        end
        @(negedge clk);
        sort_sig = 1'b0;
        chk("held_finish_count", 64'(finishes), 64'd3);
        repeat (3) @(posedge clk);
        #1;

        // Reset while in RANK.
        @(negedge clk);
        data_unsort = vecs[1].d;
        descend     = vecs[1].desc;
        sort_sig    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sort_sig = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_rank_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_finish", 64'(sort_finish), 64'd0);
        chk("mid_rst_data", 64'(data_sorted), 64'd0);
        chk("mid_rst_index", 64'(sequence_sorted), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        late_finish = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (sort_finish) begin
                late_finish++;
            end
        end
        chk("mid_rst_no_finish", 64'(late_finish), 64'd0);
        chk("mid_rst_busy_after", 64'(busy), 64'd0);
        run_vec(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parallel_rank_sort.md
Name: parallel_rank_sort

Overview:
- Parametrised parallel rank sorter for the filter datapath; successor to the fixed 25-entry, index-only sorter.
- Sorts DN unsigned DW-bit samples with a full comparison matrix and per-element rank popcount.
- Emits both the sorted data and the original indices, in ascending or descending order (selected per sort), with deterministic tie-breaking.
- Start/busy/finish handshake; feeds the trimmed-mean and median stages.

Parameters:
- DN, 25, number of elements; DN >= 2.
- DW, 8, element width in bits; unsigned.
- IW, $clog2(DN), index/rank width; derived, not to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- sort_sig  in  1  start request; sampled only in IDLE
- descend  in  1  0 = ascending, 1 = descending; sampled with sort_sig
- data_unsort  in  DW*DN  element k at [k*DW +: DW]
- data_sorted  out  DW*DN  sorted element at position p at [p*DW +: DW]
- sequence_sorted  out  IW*DN  original index of position p at [p*IW +: IW]
- busy  out  1  high while a sort is in progress
- sort_finish  out  1  one-cycle pulse; outputs are valid from this cycle on

Behaviour:
- Reset: state IDLE; data_sorted = 0, sequence_sorted = 0, busy = 0, sort_finish = 0; all internal registers cleared. Reset takes effect immediately, including mid-sort.
- One-hot FSM states: IDLE, CMP, RANK, SCAT.
- E0, IDLE with sort_sig = 1: latch data_unsort and descend; go to CMP. With sort_sig = 0, stay in IDLE.
- E1, CMP: register the DN x DN beat matrix; go to RANK.
  - Ascending: i beats j iff d_i > d_j, or d_i == d_j and i > j.
  - Descending: i beats j iff d_i < d_j, or d_i == d_j and i > j.
  - Diagonal is 0.
- E2, RANK: rank_i = popcount of row i (IW bits). Ranks form a permutation of 0..DN-1 (stable order); go to SCAT.
- E3, SCAT: data_sorted[rank_i] <= d_i and sequence_sorted[rank_i] <= i for all i; sort_finish <= 1; go to IDLE.
- sort_finish is high for exactly the cycle after E3. Latency is 3 edges from the sampling edge. Minimum start spacing is 4 cycles.
- busy = (state != IDLE), registered with the state, so it is low in the sort_finish cycle.
- sort_sig while busy is ignored, not queued. If sort_sig is held high, a new sort starts at every IDLE edge.
- Outputs hold their last result until the next SCAT edge or reset. data_unsort and descend may change freely after E0.
- Position 0 holds the smallest element (ascending) or the largest (descending). Equal values keep their input index order in both modes.

Decomposition:
- Package parallel_sort_pkg holds:
  - FSM state encodings IDLE/CMP/RANK/SCAT;
  - the beat-function definition (compare plus index tie-break);
  - a helper function for the rank width.
- Sub-module rank_popcount (DN-bit input, IW-bit count output, combinational adder tree), instantiated DN times in RANK.
- The comparison matrix and scatter stay in the top level.

Test Plan:
- DN=5, DW=8, ascending, data idx0..4 = 30,10,50,20,40 -> data_sorted = 10,20,30,40,50; sequence_sorted = 1,3,0,4,2; sort_finish 3 edges after the sampling edge; busy high for 3 cycles.
- Same data with descend=1 -> 50,40,30,20,10; indices 2,4,0,3,1.
- Ties, data 7,7,3,7,3: ascending -> 3,3,7,7,7 with indices 2,4,0,1,3; descending -> 7,7,7,3,3 with indices 0,1,3,2,4.
- All inputs 255 -> data_sorted all 255, indices 0,1,2,3,4. All inputs 0 gives the same indices.
- sort_sig held high for 12 cycles with data changing every cycle:
  - exactly 3 sorts, one sort_finish every 4 cycles;
  - each result matches the data present at its own sampling edge;
  - pulses arriving while busy have no effect.
- rst pulsed during RANK:
  - immediately busy = 0, outputs = 0, and no sort_finish follows;
  - the next sort_sig after reset release sorts correctly with normal latency.
